// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the two requester ports, the memory port and the status outputs of mem_arbiter.
// Latency: none (wires only); all timing is defined by the arbiter that drives the slave side.
// Backpressure: requesters hold cs until their ack; the memory side completes with ram_ack.
// Ports: m0_*/m1_* requester buses, ram_* memory bus, grant owner vector, served0/served1 counters.
// Modports: slave = arbiter view, master = environment view (requesters plus memory).
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // requester 0
   logic                  m0_cs;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_din;
   logic [DATA_WIDTH-1:0] m0_dout;
   logic                  m0_ack;
   // requester 1
   logic                  m1_cs;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_din;
   logic [DATA_WIDTH-1:0] m1_dout;
   logic                  m1_ack;
   // memory
   logic                  ram_cs;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  ram_ack;
   // status
   logic [1:0]            grant;
   logic [7:0]            served0;
   logic [7:0]            served1;

   modport slave (
      input  m0_cs, m0_we, m0_addr, m0_din,
      output m0_dout, m0_ack,
      input  m1_cs, m1_we, m1_addr, m1_din,
      output m1_dout, m1_ack,
      output ram_cs, ram_we, ram_addr, ram_din,
      input  ram_dout, ram_ack,
      output grant, served0, served1
   );

   modport master (
      output m0_cs, m0_we, m0_addr, m0_din,
      input  m0_dout, m0_ack,
      output m1_cs, m1_we, m1_addr, m1_din,
      input  m1_dout, m1_ack,
      input  ram_cs, ram_we, ram_addr, ram_din,
      output ram_dout, ram_ack,
      input  grant, served0, served1
   );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: two-requester round-robin arbiter in front of a single memory port (IDLE/BUSY/RELEASE FSM).
// Latency: cs sampled in IDLE at edge T -> ram_cs from cycle T+1; ram_ack after D cycles -> ack in cycle T+2+D.
// Backpressure: requesters hold cs until ack; the memory stalls BUSY until ram_ack; one IDLE cycle between grants.
// Ports: clk, rst (sync, active-high); bus = mem_arbiter_if.slave carrying requester, memory and status signals.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_owner;       // 0 = m0, 1 = m1
   logic                  r_last_grant;  // 0 = m0, 1 = m1
   logic [1:0]            r_grant;
   logic                  r_ram_cs;
   logic                  r_ram_we;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [DATA_WIDTH-1:0] r_ram_din;
   logic [DATA_WIDTH-1:0] r_m0_dout;
   logic [DATA_WIDTH-1:0] r_m1_dout;
   logic                  r_m0_ack;
   logic                  r_m1_ack;
   logic [7:0]            r_served0;
   logic [7:0]            r_served1;

   logic                  w_req;
   logic                  w_pick_m1;

   assign w_req = bus.m0_cs | bus.m1_cs;
   // m1 wins when it is the only requester, or when both request and m0 was served last.
   assign w_pick_m1 = bus.m1_cs & (~bus.m0_cs | ~r_last_grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;   // so a simultaneous first request goes to m0
         r_grant      <= 2'b00;
         r_ram_cs     <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_din    <= '0;
         r_m0_dout    <= '0;
         r_m1_dout    <= '0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_served0    <= 8'd0;
         r_served1    <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  // Request is latched here so the memory bus is immune to requester changes in BUSY.
                  r_owner    <= w_pick_m1;
                  r_grant    <= w_pick_m1 ? 2'b10 : 2'b01;
                  r_ram_cs   <= 1'b1;
                  r_ram_we   <= w_pick_m1 ? bus.m1_we   : bus.m0_we;
                  r_ram_addr <= w_pick_m1 ? bus.m1_addr : bus.m0_addr;
                  r_ram_din  <= w_pick_m1 ? bus.m1_din  : bus.m0_din;
                  r_state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (bus.ram_ack) begin
                  r_ram_cs     <= 1'b0;
                  r_last_grant <= r_owner;
                  r_state      <= ST_RELEASE;
                  if (r_owner) begin
                     r_m1_ack  <= 1'b1;
                     r_served1 <= r_served1 + 8'd1;
                     if (!r_ram_we) begin
                        r_m1_dout <= bus.ram_dout;
                     end
                  end else begin
                     r_m0_ack  <= 1'b1;
                     r_served0 <= r_served0 + 8'd1;
                     if (!r_ram_we) begin
                        r_m0_dout <= bus.ram_dout;
                     end
                  end
               end
            end
            ST_RELEASE: begin
               // Ack lasts exactly this one cycle; grant is held until now so the owner stays visible.
               r_m0_ack <= 1'b0;
               r_m1_ack <= 1'b0;
               r_grant  <= 2'b00;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ram_cs   = r_ram_cs;
   assign bus.ram_we   = r_ram_we;
   assign bus.ram_addr = r_ram_addr;
   assign bus.ram_din  = r_ram_din;
   assign bus.m0_dout  = r_m0_dout;
   assign bus.m1_dout  = r_m1_dout;
   assign bus.m0_ack   = r_m0_ack;
   assign bus.m1_ack   = r_m1_ack;
   assign bus.grant    = r_grant;
   assign bus.served0  = r_served0;
   assign bus.served1  = r_served1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with a scoreboard of expected completions.
// Latency: the memory model raises ram_ack ram_delay cycles after ram_cs first appears.
// Backpressure: requesters drop cs once their ack is seen; optional automatic re-requests.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          who;
      bit          we;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] dout;
   } txn_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   txn_t        sb[$];
   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];
   int          ram_delay = 3;
   int          busy_cnt = 0;
   bit          force_ack = 1'b0;
   bit          prev_cs = 1'b0;
   int          cs_len = 0;
   int          grant_cyc [2];
   int          ack_cyc [2];
   int          reissue [2];
   bit          raise_pending [2];
   logic [31:0] exp_dout [2];
   logic [1:0]  gseq[$];
   logic [1:0]  prev_grant = 2'b00;
   bit          owner_log[$];
   int          req_cyc = 0;
   logic [31:0] next_addr = 32'h100;
   logic [31:0] m0_before;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input bit who, input bit we, input logic [31:0] addr, input logic [31:0] din);
      txn_t t;
      t.who  = who;
      t.we   = we;
      t.addr = addr;
      t.din  = din;
      t.dout = 32'h0;
      if (we) model_mem[addr] = din;
      else    t.dout = model_mem.exists(addr) ? model_mem[addr] : dflt(addr);
      sb.push_back(t);
      if (!who) begin
         bus.m0_cs = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_din = din;
      end else begin
         bus.m1_cs = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_din = din;
      end
      req_cyc = cyc;
   endtask

   task automatic reset_model();
      sb.delete();
      exp_dout[0] = 32'h0;
      exp_dout[1] = 32'h0;
      raise_pending[0] = 1'b0;
      raise_pending[1] = 1'b0;
      reissue[0] = 0;
      reissue[1] = 0;
      busy_cnt = 0;
      force_ack = 1'b0;
      gseq.delete();
      owner_log.delete();
      prev_grant = 2'b00;
      prev_cs = 1'b0;
   endtask

   // One clock: sample 1 time unit after the edge, check, then update the requester and memory models.
   task automatic tick();
      txn_t t;
      bit   who;
      @(posedge clk);
      #1;
      cyc++;
      check("ack_exclusive", 64'(bus.m0_ack & bus.m1_ack), 64'd0);
      check("ram_cs_with_ack", 64'(bus.ram_cs & (bus.m0_ack | bus.m1_ack)), 64'd0);
      check("ram_cs_without_grant", 64'(bus.ram_cs & (bus.grant == 2'b00)), 64'd0);
      if (bus.grant != prev_grant) begin
         gseq.push_back(bus.grant);
         prev_grant = bus.grant;
      end
      if (bus.ram_cs) begin
         if (!prev_cs) begin
            cs_len = 0;
            grant_cyc[bus.grant[1]] = cyc;
            owner_log.push_back(bus.grant[1]);
         end
         cs_len++;
         if (sb.size() != 0) begin
            check("grant_owner", 64'(bus.grant), sb[0].who ? 64'd2 : 64'd1);
            check("ram_addr", 64'(bus.ram_addr), 64'(sb[0].addr));
            check("ram_we", 64'(bus.ram_we), 64'(sb[0].we));
            if (sb[0].we) check("ram_din", 64'(bus.ram_din), 64'(sb[0].din));
         end
      end
      prev_cs = bus.ram_cs;
      // re-requests scheduled on the previous ack land in the IDLE cycle
      for (int i = 0; i < 2; i++) begin
         if (raise_pending[i]) begin
            raise_pending[i] = 1'b0;
            drive_req(i[0], 1'b0, next_addr, 32'h0);
            next_addr = next_addr + 32'd4;
         end
      end
      if (bus.m0_ack || bus.m1_ack) begin
         who = bus.m1_ack;
         ack_cyc[who] = cyc;
         check("ack_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            t = sb.pop_front();
            check("ack_owner", 64'(who), 64'(t.who));
            if (!t.we) exp_dout[who] = t.dout;
            check("m0_dout", 64'(bus.m0_dout), 64'(exp_dout[0]));
            check("m1_dout", 64'(bus.m1_dout), 64'(exp_dout[1]));
         end
         if (!who) bus.m0_cs = 1'b0;
         else      bus.m1_cs = 1'b0;
         if (reissue[who] > 0) begin
            reissue[who]--;
            raise_pending[who] = 1'b1;
         end
      end
      // memory model
      if (bus.ram_cs) begin
         busy_cnt++;
         bus.ram_ack  = (busy_cnt == ram_delay + 1);
         bus.ram_dout = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : dflt(bus.ram_addr);
         if (bus.ram_ack && bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_din;
      end else begin
         busy_cnt     = 0;
         bus.ram_ack  = force_ack;
         bus.ram_dout = 32'hBAD0_BAD0;
      end
   endtask

   task automatic run_to_empty(input int max);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         tick();
         n++;
      end
      check("timeout_pending", 64'(sb.size()), 64'd0);
      tick();   // requester leaves cs low through the IDLE cycle
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.m0_cs = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_din = '0;
      bus.m1_cs = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_din = '0;
      bus.ram_ack = 1'b0; bus.ram_dout = '0;
      reset_model();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      do_reset();
      check("rst_ram_cs", 64'(bus.ram_cs), 64'd0);
      check("rst_ram_we", 64'(bus.ram_we), 64'd0);
      check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
      check("rst_ram_din", 64'(bus.ram_din), 64'd0);
      check("rst_acks", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
      check("rst_m0_dout", 64'(bus.m0_dout), 64'd0);
      check("rst_m1_dout", 64'(bus.m1_dout), 64'd0);
      check("rst_grant", 64'(bus.grant), 64'd0);
      check("rst_served", 64'({bus.served0, bus.served1}), 64'd0);

      // single m0 read, RAM delay 3
      ram_mem[32'h10]   = 32'hDEADBEEF;
      model_mem[32'h10] = 32'hDEADBEEF;
      ram_delay = 3;
      drive_req(1'b0, 1'b0, 32'h10, 32'h0);
      run_to_empty(50);
      check("lat_ram_cs", 64'(grant_cyc[0]), 64'(req_cyc + 1));
      check("lat_ack", 64'(ack_cyc[0]), 64'(grant_cyc[0] + 4));   // cycle T+5 begins at edge T+4
      check("ram_cs_len", 64'(cs_len), 64'd4);
      check("m0_dout_read", 64'(bus.m0_dout), 64'hDEADBEEF);
      check("served0_one", 64'(bus.served0), 64'd1);

      // simultaneous first requests after reset
      do_reset();
      ram_delay = 2;
      drive_req(1'b0, 1'b0, 32'h20, 32'h0);
      drive_req(1'b1, 1'b0, 32'h24, 32'h0);
      run_to_empty(80);
      check("gseq0", 64'(gseq[0]), 64'd1);
      check("gseq1", 64'(gseq[1]), 64'd0);
      check("gseq2", 64'(gseq[2]), 64'd2);
      check("m1_grant_after_idle", 64'(grant_cyc[1]), 64'(ack_cyc[0] + 2));
      check("served_both", 64'({bus.served0, bus.served1}), 64'h0101);

      // continuous requests, six transactions
      do_reset();
      ram_delay = 1;
      reissue[0] = 2;
      reissue[1] = 2;
      drive_req(1'b0, 1'b0, 32'h200, 32'h0);
      drive_req(1'b1, 1'b0, 32'h204, 32'h0);
      run_to_empty(200);
      check("owner_count", 64'(owner_log.size()), 64'd6);
      for (int i = 0; i < 6; i++) check("alternate", 64'(owner_log[i]), 64'(i % 2));
      check("served0_three", 64'(bus.served0), 64'd3);
      check("served1_three", 64'(bus.served1), 64'd3);

      // m1 write while m0 wiggles its idle inputs
      ram_delay = 3;
      m0_before = bus.m0_dout;
      drive_req(1'b1, 1'b1, 32'h04, 32'h5678_0102);
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.m0_addr = $urandom;
         bus.m0_din  = $urandom;
         bus.m0_we   = ~bus.m0_we;
      end
      run_to_empty(40);
      check("m0_dout_unchanged", 64'(bus.m0_dout), 64'(m0_before));
      drive_req(1'b0, 1'b0, 32'h04, 32'h0);
      run_to_empty(40);
      check("readback", 64'(bus.m0_dout), 64'h5678_0102);

      // reset in the second BUSY cycle, then a stale ram_ack
      drive_req(1'b0, 1'b0, 32'h40, 32'h0);
      tick();
      check("busy1_ram_cs", 64'(bus.ram_cs), 64'd1);
      tick();
      rst = 1'b1;
      bus.m0_cs = 1'b0;
      reset_model();
      tick();
      rst = 1'b0;
      check("midrst_grant", 64'(bus.grant), 64'd0);
      check("midrst_ram_cs", 64'(bus.ram_cs), 64'd0);
      force_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stale_no_ack", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
         check("stale_grant", 64'(bus.grant), 64'd0);
      end
      check("stale_served", 64'({bus.served0, bus.served1}), 64'd0);
      force_ack = 1'b0;
      tick();
      drive_req(1'b1, 1'b0, 32'h44, 32'h0);
      run_to_empty(40);
      check("post_rst_served1", 64'(bus.served1), 64'd1);
      check("post_rst_served0", 64'(bus.served0), 64'd0);

      // 256 m0 transactions wrap served0
      do_reset();
      ram_delay = 0;
      for (int i = 0; i < 256; i++) begin
         drive_req(1'b0, 1'b0, 32'(i * 4), 32'h0);
         run_to_empty(20);
         if (i == 254) check("served0_255", 64'(bus.served0), 64'd255);
      end
      check("served0_wrap", 64'(bus.served0), 64'd0);
      check("served1_zero", 64'(bus.served1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
